// File: rtl/johnson_rx_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Module : johnson_rx_decoder_pkg
// Brief  : Shared state type and Johnson-code legality/index helpers.
// Rev    : 1.0  initial release
// ============================================================================
package johnson_rx_decoder_pkg;

  localparam int MAX_W = 32;
  localparam int IW    = $clog2(2 * 8);

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } rx_state_e;

  // A legal Johnson code has at most one 0/1 boundary inside the low 'width' bits
  function automatic logic johnson_legal(input logic [MAX_W-1:0] code, input int width);
    int n_edges;
    n_edges = 0;
    for (int i = 0; i < MAX_W - 1; i++) begin
      if ((i < width - 1) && (code[i] != code[i+1])) n_edges++;
    end
    return (n_edges <= 1);
  endfunction

  function automatic int johnson_index(input logic [MAX_W-1:0] code, input int width);
    int pc;
    pc = 0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < width) pc += int'(code[i]);
    end
    return code[width-1] ? (2 * width - pc) : pc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/johnson_code_check.sv
`default_nettype none
// ============================================================================
// Module : johnson_code_check
// Brief  : Combinational Johnson code legality check and state-index decode.
// Rev    : 1.0  initial release
// ============================================================================
module johnson_code_check
  import johnson_rx_decoder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(2 * WIDTH)
) (
  input  logic [WIDTH-1:0] i_code,
  output logic             o_legal,
  output logic [IDX_W-1:0] o_index
);

  logic [MAX_W-1:0] w_code_ext;

  always_comb begin
    w_code_ext             = '0;
    w_code_ext[WIDTH-1:0]  = i_code;
    o_legal                = johnson_legal(w_code_ext, WIDTH);
    o_index                = IDX_W'(johnson_index(w_code_ext, WIDTH));
  end

endmodule
`default_nettype wire

// File: rtl/johnson_rx_decoder.sv
`default_nettype none
// ============================================================================
// Module : johnson_rx_decoder
// Brief  : Samples and validates a Johnson code, tracks direction/position/lock.
// Rev    : 1.0  initial release
// ============================================================================
module johnson_rx_decoder
  import johnson_rx_decoder_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int POS_W    = 8,
  parameter int LOCK_CNT = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ena,
  input  logic [WIDTH-1:0]             code_in,
  input  logic                         code_valid,
  output logic [$clog2(2*WIDTH)-1:0]   index,
  output logic [POS_W-1:0]             pos,
  output logic                         dir,
  output logic                         step,
  output logic                         locked,
  output logic                         err_illegal,
  output logic                         err_skip,
  output logic [7:0]                   err_cnt
);

  localparam int c_IW   = $clog2(2 * WIDTH);
  localparam int c_RING = 2 * WIDTH;
  localparam int c_LCW  = $clog2(LOCK_CNT + 1);

  // Stage 1: input capture
  logic [WIDTH-1:0] r_code;
  logic             r_vld;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_code <= '0;
      r_vld  <= 1'b0;
    end else if (ena && code_valid) begin
      r_code <= code_in;
      r_vld  <= 1'b1;
    end else begin
      r_vld  <= 1'b0;
    end
  end

  logic            w_legal;
  logic [c_IW-1:0] w_k;

  johnson_code_check #(
    .WIDTH (WIDTH),
    .IDX_W (c_IW)
  ) u_code_check (
    .i_code  (r_code),
    .o_legal (w_legal),
    .o_index (w_k)
  );

  // Stage 2: r_index doubles as the previous-legal-index reference
  rx_state_e        r_state, w_state_nxt;
  logic [c_LCW-1:0] r_lock, w_lock_nxt;
  logic [c_IW-1:0]  r_index, w_index_nxt;
  logic [POS_W-1:0] r_pos, w_pos_nxt;
  logic             r_dir, w_dir_nxt;
  logic             r_step, w_step_nxt;
  logic             r_ill, w_ill_nxt;
  logic             r_skip, w_skip_nxt;
  logic [7:0]       r_err_cnt, w_err_cnt_nxt;
  int               w_delta;
  logic             w_up, w_dn, w_hold, w_adj;

  always_comb begin
    w_delta = (int'(w_k) - int'(r_index) + c_RING) % c_RING;
    w_up    = (w_delta == 1);
    w_dn    = (w_delta == c_RING - 1);
    w_hold  = (w_delta == 0);
    w_adj   = w_up || w_dn || w_hold;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= UNLOCKED;
      r_lock  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lock  <= w_lock_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lock_nxt  = r_lock;
    if (r_vld) begin
      if (!w_legal) begin
        w_state_nxt = UNLOCKED;
        w_lock_nxt  = '0;
      end else begin
        case (r_state)
          UNLOCKED: begin
            if ((r_lock == '0) || !w_adj) w_lock_nxt = c_LCW'(1);
            else                          w_lock_nxt = r_lock + c_LCW'(1);
            if (w_lock_nxt == c_LCW'(LOCK_CNT)) w_state_nxt = LOCKED;
          end
          LOCKED: begin
            if (!w_adj) begin
              w_state_nxt = UNLOCKED;
              w_lock_nxt  = c_LCW'(1);
            end
          end
          default: w_state_nxt = UNLOCKED;
        endcase
      end
    end
  end

  always_comb begin
    w_index_nxt = r_index;
    w_pos_nxt   = r_pos;
    w_dir_nxt   = r_dir;
    w_step_nxt  = 1'b0;
    w_ill_nxt   = 1'b0;
    w_skip_nxt  = 1'b0;
    if (r_vld) begin
      if (!w_legal) begin
        w_ill_nxt = 1'b1;
      end else begin
        w_index_nxt = w_k;
        if (r_state == LOCKED) begin
          if (w_up) begin
            w_pos_nxt  = r_pos + POS_W'(1);
            w_dir_nxt  = 1'b1;
            w_step_nxt = 1'b1;
          end else if (w_dn) begin
            w_pos_nxt  = r_pos - POS_W'(1);
            w_dir_nxt  = 1'b0;
            w_step_nxt = 1'b1;
          end else if (!w_hold) begin
            w_skip_nxt = 1'b1;
          end
        end
      end
    end
    w_err_cnt_nxt = r_err_cnt;
    if ((w_ill_nxt || w_skip_nxt) && (r_err_cnt != 8'hFF)) w_err_cnt_nxt = r_err_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_index   <= '0;
      r_pos     <= '0;
      r_dir     <= 1'b0;
      r_step    <= 1'b0;
      r_ill     <= 1'b0;
      r_skip    <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_index   <= w_index_nxt;
      r_pos     <= w_pos_nxt;
      r_dir     <= w_dir_nxt;
      r_step    <= w_step_nxt;
      r_ill     <= w_ill_nxt;
      r_skip    <= w_skip_nxt;
      r_err_cnt <= w_err_cnt_nxt;
    end
  end

  assign index       = r_index;
  assign pos         = r_pos;
  assign dir         = r_dir;
  assign step        = r_step;
  assign locked      = (r_state == LOCKED);
  assign err_illegal = r_ill;
  assign err_skip    = r_skip;
  assign err_cnt     = r_err_cnt;

endmodule
`default_nettype wire

// File: doc/johnson_rx_decoder.md
Name: johnson_rx_decoder

Overview:
Receive-side counterpart of the Johnson counter. It samples a WIDTH-bit Johnson code from an external counter or pad bus and validates it, then decodes it to a state index. It tracks step direction and an accumulated position, and flags illegal codes and skipped states. It sits between the Johnson input pins and downstream position/status logic in the tile.

Parameters:
WIDTH, 8, Johnson code width; ring has 2*WIDTH states; index width IW = clog2(2*WIDTH) (4 at default)
POS_W, 8, width of the accumulated position counter
LOCK_CNT, 2, consecutive legal, adjacent samples needed to reach LOCKED (>=1)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous, active-high reset (1 = reset); name kept per codebase
ena  in  1  block enable; low = no capture, all state held
code_in  in  WIDTH  Johnson code sample
code_valid  in  1  code_in qualifier
index  out  IW  decoded state index of the last legal sample
pos  out  POS_W  accumulated position, modulo 2^POS_W
dir  out  1  direction of last accepted step (1 = up, 0 = down)
step  out  1  one-cycle pulse per accepted step while LOCKED
locked  out  1  high in the LOCKED state
err_illegal  out  1  one-cycle pulse on an illegal code
err_skip  out  1  one-cycle pulse on a non-adjacent jump while LOCKED
err_cnt  out  8  saturating count of err_illegal plus err_skip events

Behaviour:
- Reset: all outputs and registers are 0; the state is UNLOCKED; the internal lock counter is 0.
- Code sequence (up direction): next = {code[WIDTH-2:0], ~code[WIDTH-1]}. Starting from 0x00 the sequence is 0x00, 0x01, 0x03 ... 0xFF, 0xFE ... 0x80, then back to 0x00.
- Legal code: the bits form 0..01..1 or 1..10..0 (at most one 0/1 boundary, excluding the wrap).
- Decode: if code[WIDTH-1]=0, k = popcount. Otherwise k = 2*WIDTH - popcount. Examples: 0xFF gives 8, 0x80 gives 15.
- Stage 1: when ena and code_valid, code_in is registered and a valid flag is set. Otherwise the valid flag is cleared.
- Stage 2: operates on the registered sample. Outputs change on the edge after capture, so the response is visible 2 edges after code_in is presented.
- delta = (k - prev_k) mod 2*WIDTH. prev_k updates on every legal sample.
- UNLOCKED state:
  - First legal sample: lock counter = 1.
  - Each further legal sample with delta in {0, 1, 2W-1}: lock counter increments.
  - Other delta: lock counter = 1.
  - When the lock counter reaches LOCK_CNT, go to LOCKED.
  - pos, dir and step are unchanged throughout UNLOCKED, including on the locking sample.
- LOCKED state:
  - delta 0: no change.
  - delta 1: pos+1, dir=1, step=1.
  - delta 2W-1: pos-1, dir=0, step=1.
  - Any other delta: err_skip=1, go to UNLOCKED with lock counter = 1 (sample taken as the new reference), pos held.
- Illegal code in any state: err_illegal=1, go to UNLOCKED, lock counter = 0, index/prev_k/pos held.
- Wrap-around:
  - Index 15 to 0 is delta 1 (up); 0 to 15 is delta 2W-1 (down).
  - pos wraps 2^POS_W-1 to 0 and 0 to 2^POS_W-1 without any flag.
- err_cnt increments on either error pulse and saturates at 255. Only one error pulse can occur per sample.
- index updates on every legal sample in either state.
- ena low mid-stream: stage-1 valid is cleared and all state holds. When ena returns, the delta is computed against the held prev_k.
- Reset asserted mid-operation overrides everything on that edge, including an in-flight sample.

Decomposition:
- Shared package: state enum (UNLOCKED, LOCKED), function johnson_legal(code), function johnson_index(code), constant IW.
- One sub-module is natural: johnson_code_check (combinational legal + index decode), reusable by a future self-checking transmitter.

Test Plan:
1. Reset then up sweep 0x00, 0x01, 0x03 ... 0x80, 0x00, 0x01 with code_valid=1 each cycle -> locked after the 2nd sample. 16 step pulses follow. dir=1, pos=16, index=1. No errors.
2. Locked at 0x07 (index 3), then present 0x03 -> index=2, dir=0, step pulse, pos decrements by 1.
3. Locked, then present 0x05 -> err_illegal pulse, locked=0, pos/index unchanged, err_cnt=1.
4. Locked at 0x01, then present 0x0F -> err_skip pulse, locked=0. Then 0x1F, 0x3F -> relocks after 0x1F, step on 0x3F.
5. Locked with pos=0xFF, step up -> pos=0x00. Then step down -> pos=0xFF. No flags.
6. Mid-sweep: drop ena for 3 cycles, then resume with the next adjacent code -> no error, step resumes. Assert rst_n for one cycle mid-sweep -> all outputs 0, locked=0 on the following cycle.
